// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word width, instruction size, fetch FSM states.
package cpu_pkg;

    localparam int WORD_W      = 16;
    localparam int INSTR_BYTES = 2;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
        return pc + WORD_W'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/if2id_reg.sv
// IF/ID pipeline register: load has priority over clear; otherwise contents hold.
module if2id_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] pc_in,
    output logic              valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_inc
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] pc_inc_q, pc_inc_d;

    always_comb begin
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        pc_inc_d = pc_inc_q;
        if (load) begin
            valid_d  = 1'b1;
            instr_d  = instr_in;
            pc_d     = pc_in;
            pc_inc_d = next_pc(pc_in);
        end else if (clear) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_q     <= '0;
            pc_inc_q <= '0;
        end else begin
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            pc_inc_q <= pc_inc_d;
        end
    end

    assign valid  = valid_q;
    assign instr  = instr_q;
    assign pc     = pc_q;
    assign pc_inc = pc_inc_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC, request FSM (REQ/HOLD/DRAIN/HALT), one-entry hold buffer.
// Define FETCH_PERF_EN to add the saturating stall_cycles counter output.
module fetch
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze_pc,
    input  logic              freeze_if2id,
    input  logic              flush_if2id,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_done,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              IF2ID_valid,
    output logic [WORD_W-1:0] IF2ID_instr,
    output logic [WORD_W-1:0] IF2ID_pc,
    output logic [WORD_W-1:0] IF2ID_pc_inc,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       stall_cycles
`endif
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [WORD_W-1:0] drain_addr_q, drain_addr_d;
    logic              halt_pend_q, halt_pend_d;

    logic              stall;
    logic              req;
    logic              if2id_load;
    logic              if2id_clear;
    logic [WORD_W-1:0] load_instr;

    always_comb begin
        stall        = freeze_pc | freeze_if2id;
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        drain_addr_d = drain_addr_q;
        halt_pend_d  = halt_pend_q;
        req          = 1'b0;
        imem_addr    = pc_q;
        if2id_load   = 1'b0;
        if2id_clear  = flush_if2id;
        load_instr   = imem_rdata;

        unique case (state_q)
            REQ: begin
                req = 1'b1;
                if (redirect_valid) begin
                    pc_d         = redirect_pc;
                    if2id_clear  = 1'b1;
                    drain_addr_d = pc_q;
                    halt_pend_d  = 1'b0;
                    state_d      = imem_done ? REQ : DRAIN;
                end else if (halt) begin
                    if2id_clear  = 1'b1;
                    drain_addr_d = pc_q;
                    halt_pend_d  = !imem_done;
                    state_d      = imem_done ? HALT : DRAIN;
                end else if (imem_done && !stall) begin
                    if2id_load = 1'b1;
                    pc_d       = next_pc(pc_q);
                end else if (imem_done) begin
                    hold_d  = imem_rdata;
                    state_d = HOLD;
                end else if (!stall) begin
                    if2id_clear = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    if2id_clear = 1'b1;
                    state_d     = REQ;
                end else if (halt) begin
                    if2id_clear = 1'b1;
                    state_d     = HALT;
                end else if (!stall) begin
                    if2id_load = 1'b1;
                    load_instr = hold_q;
                    pc_d       = next_pc(pc_q);
                    state_d    = REQ;
                end
            end
            DRAIN: begin
                // Old access must complete at its own address; its data is dropped.
                req         = 1'b1;
                imem_addr   = drain_addr_q;
                if2id_clear = 1'b1;
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    halt_pend_d = 1'b0;
                    state_d     = imem_done ? REQ : DRAIN;
                end else if (halt) begin
                    if (imem_done) state_d = HALT;
                    else           halt_pend_d = 1'b1;
                end else if (imem_done) begin
                    state_d = halt_pend_q ? HALT : REQ;
                end
            end
            HALT: begin
                if2id_clear = 1'b1;
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            hold_q       <= '0;
            drain_addr_q <= '0;
            halt_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            drain_addr_q <= drain_addr_d;
            halt_pend_q  <= halt_pend_d;
        end
    end

    // Gated so no request is issued while the memory is itself held in reset.
    assign imem_req = req & rst_n;
    assign halted   = (state_q == HALT);

    if2id_reg u_if2id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (if2id_load),
        .clear    (if2id_clear),
        .instr_in (load_instr),
        .pc_in    (pc_q),
        .valid    (IF2ID_valid),
        .instr    (IF2ID_instr),
        .pc       (IF2ID_pc),
        .pc_inc   (IF2ID_pc_inc)
    );

`ifdef FETCH_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_cycle;

    always_comb begin
        stall_cycle = ((state_q == REQ) && !imem_done) || (state_q == HOLD) || (state_q == DRAIN);
        stall_cnt_d = stall_cnt_q;
        if (stall_cycle && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule
